// File: rtl/debug_host_master.sv
// Avalon-MM master that drives a CPU debug slave's register window from single host commands.
// Optional build macro DEBUG_HOST_TIMEOUT_EN bounds each waitrequest stall to TIMEOUT_CYCLES.
module debug_host_master #(
    parameter int         READ_LATENCY   = 1,
    parameter int         POST_WAIT      = 4,
    parameter logic [2:0] RDBK_ADDR      = 3'd3,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [31:0] cmd_wdata2,
    input  logic [31:0] cmd_ctrl,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    output logic        avm_chipselect,
    output logic        avm_write,
    output logic        avm_read,
    output logic [2:0]  avm_address,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        XFER_WR = 3'd1,
        XFER_RD = 3'd2,
        RD_WAIT = 3'd3,
        GAP     = 3'd4,
        RESP    = 3'd5
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'((POST_WAIT == 0) ? 0 : POST_WAIT - 1);
    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY);

    state_t      state_r;
    logic [1:0]  op_r;
    logic [1:0]  step_r;
    logic [31:0] mem_data_r;
    logic [31:0] ctrl_r;
    logic [7:0]  gap_cnt_r;
    logic [2:0]  lat_cnt_r;

`ifdef DEBUG_HOST_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] to_cnt_r;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
`endif

    // Command sequencer: state, captured command and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            op_r           <= 2'b00;
            step_r         <= 2'd0;
            mem_data_r     <= 32'd0;
            ctrl_r         <= 32'd0;
            gap_cnt_r      <= 8'd0;
            lat_cnt_r      <= 3'd0;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_data       <= 32'd0;
            rsp_error      <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            avm_address    <= 3'd0;
            avm_writedata  <= 32'd0;
`ifdef DEBUG_HOST_TIMEOUT_EN
            to_cnt_r       <= 32'd0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_r       <= cmd_op;
                        step_r     <= 2'd0;
                        mem_data_r <= cmd_wdata2;
                        ctrl_r     <= cmd_ctrl;
                        cmd_ready  <= 1'b0;
`ifdef DEBUG_HOST_TIMEOUT_EN
                        to_cnt_r   <= 32'd0;
`endif
                        case (cmd_op)
                            2'b00, 2'b10: begin
                                state_r        <= XFER_WR;
                                avm_chipselect <= 1'b1;
                                avm_write      <= 1'b1;
                                avm_address    <= (cmd_op == 2'b10) ? 3'd1 : cmd_addr;
                                avm_writedata  <= cmd_wdata;
                            end
                            2'b01: begin
                                state_r        <= XFER_RD;
                                avm_chipselect <= 1'b1;
                                avm_read       <= 1'b1;
                                avm_address    <= cmd_addr;
                            end
                            default: begin
                                state_r   <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_data  <= 32'd0;
                                rsp_error <= 1'b1;
                            end
                        endcase
                    end
                end
                XFER_WR, XFER_RD: begin
                    if (!avm_waitrequest) begin
`ifdef DEBUG_HOST_TIMEOUT_EN
                        to_cnt_r <= 32'd0;
`endif
                        if (state_r == XFER_WR && op_r == 2'b10 && step_r == 2'd0) begin
                            step_r        <= 2'd1;
                            avm_address   <= 3'd2;
                            avm_writedata <= mem_data_r;
                        end else if (state_r == XFER_WR && op_r == 2'b10 && step_r == 2'd1) begin
                            step_r        <= 2'd2;
                            avm_address   <= 3'd0;
                            avm_writedata <= ctrl_r;
                        end else if (state_r == XFER_WR && op_r == 2'b10) begin
                            avm_write     <= 1'b0;
                            avm_writedata <= 32'd0;
                            if (POST_WAIT == 0) begin
                                state_r     <= XFER_RD;
                                avm_read    <= 1'b1;
                                avm_address <= RDBK_ADDR;
                            end else begin
                                state_r        <= GAP;
                                gap_cnt_r      <= 8'd0;
                                avm_chipselect <= 1'b0;
                                avm_address    <= 3'd0;
                            end
                        end else begin
                            avm_chipselect <= 1'b0;
                            avm_write      <= 1'b0;
                            avm_read       <= 1'b0;
                            avm_address    <= 3'd0;
                            avm_writedata  <= 32'd0;
                            if (state_r == XFER_WR) begin
                                state_r   <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_data  <= 32'd0;
                                rsp_error <= 1'b0;
                            end else if (READ_LATENCY == 0) begin
                                state_r   <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_data  <= avm_readdata;
                                rsp_error <= 1'b0;
                            end else begin
                                state_r   <= RD_WAIT;
                                lat_cnt_r <= 3'd1;
                            end
                        end
                    end else begin
`ifdef DEBUG_HOST_TIMEOUT_EN
                        // A stuck slave releases the bus and abandons the rest of the command.
                        if (to_cnt_r == TO_LAST) begin
                            state_r        <= RESP;
                            rsp_valid      <= 1'b1;
                            rsp_data       <= 32'd0;
                            rsp_error      <= 1'b1;
                            avm_chipselect <= 1'b0;
                            avm_write      <= 1'b0;
                            avm_read       <= 1'b0;
                            avm_address    <= 3'd0;
                            avm_writedata  <= 32'd0;
                            to_cnt_r       <= 32'd0;
                        end else begin
                            to_cnt_r <= to_cnt_r + 32'd1;
                        end
`endif
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        state_r   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= avm_readdata;
                        rsp_error <= 1'b0;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 3'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r        <= XFER_RD;
                        avm_chipselect <= 1'b1;
                        avm_read       <= 1'b1;
                        avm_address    <= RDBK_ADDR;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 8'd1;
                    end
                end
                RESP: begin
                    state_r   <= IDLE;
                    cmd_ready <= 1'b1;
                    rsp_data  <= 32'd0;
                    rsp_error <= 1'b0;
                end
                default: begin
                    state_r        <= IDLE;
                    cmd_ready      <= 1'b1;
                    avm_chipselect <= 1'b0;
                    avm_write      <= 1'b0;
                    avm_read       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_debug_host_master.sv
// Scoreboard bench for debug_host_master: bus-slave model, expected-transfer and response queues.
module tb_debug_host_master;
    localparam int RL = 1;
    localparam int PW = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [2:0]  cmd_addr = 3'd0;
    logic [31:0] cmd_wdata = 32'd0, cmd_wdata2 = 32'd0, cmd_ctrl = 32'd0;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_data;
    logic        avm_chipselect, avm_write, avm_read;
    logic [2:0]  avm_address;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_waitrequest = 1'b0;

    debug_host_master #(.READ_LATENCY(RL), .POST_WAIT(PW), .RDBK_ADDR(3'd3), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wdata2(cmd_wdata2), .cmd_ctrl(cmd_ctrl),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_read(avm_read),
        .avm_address(avm_address), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest));

    always #5 clk = ~clk;

    typedef struct {logic [31:0] data; logic err; int lat; int acc;} rsp_t;
    typedef struct {logic wr; logic [2:0] addr; logic [31:0] data;} bus_t;

    rsp_t        rsp_q[$];
    bus_t        bus_q[$];
    int          checks = 0, errors = 0, cyc = 0;
    logic [31:0] ref_mem[8];
    logic [31:0] slv_mem[8];
    logic [31:0] rdbk_val = 32'd0;
    int          stall_addr2 = 0;
    bit          rand_stall = 1'b0, stuck = 1'b0;
    int          pend_cnt = -1;
    logic [31:0] pend_data, rv;
    logic        w, prev_stall = 1'b0;
    logic [36:0] prev_vec;
    bus_t        be;
    rsp_t        re;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model plus monitor: stalls, read-data timing, transfer and response scoreboards.
    always @(negedge clk) begin
        if (!rst_n) begin
            avm_waitrequest = 1'b0;
            pend_cnt = -1;
            prev_stall = 1'b0;
        end else begin
            avm_readdata = $urandom;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    avm_readdata = pend_data;
                    pend_cnt = -1;
                end
            end
            w = 1'b0;
            if (avm_chipselect) begin
                if (stuck) w = 1'b1;
                else if (avm_write && avm_address == 3'd2 && stall_addr2 > 0) begin
                    w = 1'b1;
                    stall_addr2--;
                end else if (rand_stall && $urandom_range(0, 3) == 0) w = 1'b1;
            end
            avm_waitrequest = w;
            if (prev_stall && avm_chipselect)
                chk("stall_stable", {avm_read, avm_write, avm_address, avm_writedata}, prev_vec);
            prev_stall = avm_chipselect && w;
            prev_vec = {avm_read, avm_write, avm_address, avm_writedata};
            if (avm_chipselect) chk("rd_wr_exclusive", avm_read & avm_write, 1'b0);
            else chk("idle_bus", {avm_read, avm_write}, 2'b00);
            if (avm_chipselect && !w) begin
                chk("bus_expected", bus_q.size() != 0, 1'b1);
                if (bus_q.size() != 0) begin
                    be = bus_q.pop_front();
                    chk("bus_kind", avm_write, be.wr);
                    chk("bus_addr", avm_address, be.addr);
                    if (be.wr) chk("bus_wdata", avm_writedata, be.data);
                end
                if (avm_write) begin
                    if (avm_address != 3'd3) slv_mem[avm_address] = avm_writedata;
                end else begin
                    rv = (avm_address == 3'd3) ? rdbk_val : slv_mem[avm_address];
                    if (RL == 0) avm_readdata = rv;
                    else begin
                        pend_data = rv;
                        pend_cnt = RL;
                    end
                end
            end
            if (rsp_valid) begin
                chk("rsp_expected", rsp_q.size() != 0, 1'b1);
                if (rsp_q.size() != 0) begin
                    re = rsp_q.pop_front();
                    chk("rsp_data", rsp_data, re.data);
                    chk("rsp_error", rsp_error, re.err);
                    if (re.lat >= 0) chk("rsp_latency", 64'(cyc - re.acc), 64'(re.lat));
                end
            end
        end
    end

    // Offer a command, hold it until accepted, then record what the bus and response must be.
    task automatic issue(input logic [1:0] op, input logic [2:0] addr, input logic [31:0] wd,
                         input logic [31:0] wd2, input logic [31:0] ctrl, input logic [31:0] rb,
                         input int lat_add, input bit to_exp);
        int   guard = 0;
        rsp_t r;
        cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_wdata2 = wd2; cmd_ctrl = ctrl;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cmd_ready !== 1'b1) begin
            chk("cmd_accept", cmd_ready, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        rdbk_val = rb;
        r.acc = cyc;
        r.err = 1'b0;
        r.data = 32'd0;
        r.lat = 0;
        if (to_exp) begin
            r.err = 1'b1;
            r.lat = 1 + TO;
        end else begin
            case (op)
                2'b00: begin
                    bus_q.push_back('{1'b1, addr, wd});
                    if (addr != 3'd3) ref_mem[addr] = wd;
                    r.lat = 2;
                end
                2'b01: begin
                    bus_q.push_back('{1'b0, addr, 32'd0});
                    r.data = (addr == 3'd3) ? rb : ref_mem[addr];
                    r.lat = 2 + RL;
                end
                2'b10: begin
                    bus_q.push_back('{1'b1, 3'd1, wd});
                    bus_q.push_back('{1'b1, 3'd2, wd2});
                    bus_q.push_back('{1'b1, 3'd0, ctrl});
                    bus_q.push_back('{1'b0, 3'd3, 32'd0});
                    ref_mem[1] = wd; ref_mem[2] = wd2; ref_mem[0] = ctrl;
                    r.data = rb;
                    r.lat = 3 + PW + 2 + RL;
                end
                default: begin
                    r.err = 1'b1;
                    r.lat = 1;
                end
            endcase
        end
        r.lat = (lat_add < 0) ? -1 : r.lat + lat_add;
        rsp_q.push_back(r);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_addr = 3'($urandom); cmd_wdata = $urandom;
        cmd_wdata2 = $urandom; cmd_ctrl = $urandom;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_rsp", rsp_q.size(), 0);
        chk("drain_bus", bus_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = 32'd0;
            slv_mem[i] = 32'd0;
        end
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        chk("reset_bus", {avm_chipselect, avm_read, avm_write, avm_address, avm_writedata}, 64'd0);
        chk("reset_rsp", {rsp_valid, rsp_error, rsp_data}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", cmd_ready, 1'b1);

        issue(2'b00, 3'd0, 32'h0000_0001, 32'd0, 32'd0, 32'd0, 0, 1'b0);
        wait_idle(100);
        issue(2'b01, 3'd3, 32'd0, 32'd0, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);
        wait_idle(100);
        issue(2'b10, 3'd0, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0000_0008, 32'h1234_5678, 0, 1'b0);
        wait_idle(100);
        stall_addr2 = 5;
        issue(2'b10, 3'd0, 32'h0000_0200, 32'h5A5A_5A5A, 32'h0000_0009, 32'hCAFE_F00D, 5, 1'b0);
        wait_idle(100);
        issue(2'b11, 3'd5, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 0, 1'b0);
        wait_idle(100);
        issue(2'b01, 3'd1, 32'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0);
        wait_idle(100);
`ifdef DEBUG_HOST_TIMEOUT_EN
        stuck = 1'b1;
        issue(2'b01, 3'd2, 32'd0, 32'd0, 32'd0, 32'd0, 0, 1'b1);
        wait_idle(200);
        stuck = 1'b0;
`endif
        stall_addr2 = 100;
        issue(2'b10, 3'd0, 32'h0000_0300, 32'h0F0F_0F0F, 32'h0000_0001, 32'h0BAD_CAFE, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_bus", {avm_chipselect, avm_read, avm_write}, 3'b000);
        chk("midreset_rsp_valid", rsp_valid, 1'b0);
        chk("midreset_cmd_ready", cmd_ready, 1'b1);
        rsp_q.delete();
        bus_q.delete();
        stall_addr2 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) ref_mem[i] = slv_mem[i];
        repeat (3) @(negedge clk);
        chk("after_midreset_cmd_ready", cmd_ready, 1'b1);

        rand_stall = 1'b1;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(2'($urandom_range(0, 3)), 3'($urandom), $urandom, $urandom, $urandom, $urandom, -1, 1'b0);
        end
        wait_idle(2000);
        rand_stall = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/debug_host_master.md
Name: debug_host_master

Overview:
- Avalon-MM master that drives the CPU debug slave's register window: control reg 0, address reg 1, data reg 2, read-back reg 3.
- Accepts single-entry commands from a host-side source (JTAG/UART bridge) over a valid/ready port.
- Runs single register writes or reads, or a composite "debug memory access" sequence (address, data, control, settle, read-back).
- Returns one response per command.

Parameters:
- READ_LATENCY, 1: cycles from accepted read (read=1, waitrequest=0) to readdata sampled; legal 0..7.
- POST_WAIT, 4: idle cycles between the control write and the read-back read in a composite op; legal 0..255.
- RDBK_ADDR, 3: slave address read at the end of a composite op.
- TIMEOUT_CYCLES, 1024: waitrequest limit per transfer (only with the optional feature).

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  00 write, 01 read, 10 composite, 11 reserved
- cmd_addr  in  3  slave register address (ops 00/01)
- cmd_wdata  in  32  write data (00) / memory address (10)
- cmd_wdata2  in  32  memory data (10)
- cmd_ctrl  in  32  control word written to reg 0 (10)
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  32  read data (01/10), 0 for 00
- rsp_error  out  1  reserved op or timeout
- avm_chipselect, avm_write, avm_read  out  1  Avalon master controls
- avm_address  out  3  slave address
- avm_writedata  out  32  write data
- avm_readdata  in  32  slave read data
- avm_waitrequest  in  1  slave stall; tie 0 if unused

Behaviour:
- Reset (RST_N=0, asynchronous): state IDLE; all outputs 0 except cmd_ready=1; counters cleared. Reset mid-transfer drops the transfer with no response.
- States: IDLE, XFER_WR, XFER_RD, RD_WAIT, GAP, RESP.
- IDLE: cmd_ready=1.
  - On valid&ready, capture all cmd fields and set step=0.
  - Op 00 -> XFER_WR; op 01 -> XFER_RD; op 10 -> XFER_WR (step 0).
  - Op 11 -> RESP with rsp_error=1 and rsp_data=0.
  - cmd_ready=0 in every other state, so the next command is accepted at the earliest the cycle after RESP.
- XFER_WR: chipselect=1, write=1, address/writedata held stable until a cycle with waitrequest=0 (completes in that cycle).
  - Op 00 -> RESP.
  - Op 10 sequence: step0 addr1 = memory address; step1 addr2 = memory data; step2 addr0 = cmd_ctrl. Step increments per completed write.
  - After step2: -> GAP, or -> XFER_RD if POST_WAIT=0.
- GAP: count POST_WAIT cycles with bus idle (all avm controls 0), then -> XFER_RD with address RDBK_ADDR.
- XFER_RD: chipselect=1, read=1 until waitrequest=0.
  - READ_LATENCY=0: sample readdata in the accept cycle -> RESP.
  - Otherwise -> RD_WAIT.
- RD_WAIT: bus idle; sample avm_readdata exactly READ_LATENCY cycles after the accept cycle -> RESP.
- RESP: rsp_valid=1 for exactly one cycle with rsp_data and rsp_error; no backpressure. Next cycle -> IDLE.
- Never more than one outstanding transfer; read and write are never asserted together.
- Response latency with waitrequest=0 and READ_LATENCY=1:
  - op 00: rsp_valid 2 cycles after accept.
  - op 01: 3 cycles after accept.
  - op 10: 4+POST_WAIT+2 cycles after accept.

Optional Feature:
- DEBUG_HOST_TIMEOUT_EN defined: a counter runs while any transfer is stalled by waitrequest and clears on completion. When it reaches TIMEOUT_CYCLES, the master drops chipselect/read/write and goes to RESP with rsp_error=1 and rsp_data=0. The remaining composite steps are abandoned.
- Undefined: no counter; the master waits on waitrequest indefinitely.

Test Plan:
- Op 00, addr 0, wdata 0x0000_0001, waitrequest=0 -> one write cycle (address 0, writedata 0x1); rsp_valid 2 cycles after accept, rsp_data 0, rsp_error 0.
- Op 01, addr 3, slave returns 0xDEAD_BEEF at latency 1 -> one read cycle; rsp_data 0xDEAD_BEEF 3 cycles after accept.
- Op 10, addr 0x100, data 0xA5A5_A5A5, ctrl 0x0000_0008, POST_WAIT=4, read-back 0x1234_5678 -> writes to addresses 1, 2, 0 in order, 4 idle cycles, read of address 3; rsp_data 0x1234_5678.
- waitrequest held 5 cycles during the step1 write -> address/writedata stable all 5 cycles, sequence resumes with no duplicate write.
- Op 11 -> no bus activity; rsp_valid with rsp_error=1 one cycle after accept.
- DEBUG_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=16, waitrequest stuck 1 -> bus released after 16 stall cycles, rsp_error=1. Separately, RST_N low mid-composite -> all avm outputs 0 immediately, no response, cmd_ready=1 after reset.
